// File: rtl/radix2_sdf_delay_stage.sv
// rtl/radix2_sdf_delay_stage.sv - radix-2 SDF stage front end: feedback delay line, butterfly pairing, output merge
module radix2_sdf_delay_stage #(
    parameter int DATA_WIDTH_IN  = 10,
    parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
    parameter int DELAY          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [DATA_WIDTH_IN-1:0]  in_real,
    input  logic [DATA_WIDTH_IN-1:0]  in_imag,
    output logic [DATA_WIDTH_IN-1:0]  bf_ain_real,
    output logic [DATA_WIDTH_IN-1:0]  bf_ain_imag,
    output logic [DATA_WIDTH_IN-1:0]  bf_bin_real,
    output logic [DATA_WIDTH_IN-1:0]  bf_bin_imag,
    input  logic [DATA_WIDTH_OUT-1:0] bf_aout_real,
    input  logic [DATA_WIDTH_OUT-1:0] bf_aout_imag,
    input  logic [DATA_WIDTH_OUT-1:0] bf_bout_real,
    input  logic [DATA_WIDTH_OUT-1:0] bf_bout_imag,
    output logic                      out_valid,
    output logic [DATA_WIDTH_OUT-1:0] out_real,
    output logic [DATA_WIDTH_OUT-1:0] out_imag
);
    localparam int CW = $clog2(2 * DELAY);
    localparam int EW = DATA_WIDTH_OUT - DATA_WIDTH_IN;

    logic [CW-1:0]             cnt_q, cnt_d, idx;
    logic                      is_bfly;
    logic                      primed_q, primed_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH_OUT-1:0] out_real_q, out_real_d;
    logic [DATA_WIDTH_OUT-1:0] out_imag_q, out_imag_d;
    logic [DATA_WIDTH_OUT-1:0] dl_re_q [DELAY];
    logic [DATA_WIDTH_OUT-1:0] dl_re_d [DELAY];
    logic [DATA_WIDTH_OUT-1:0] dl_im_q [DELAY];
    logic [DATA_WIDTH_OUT-1:0] dl_im_d [DELAY];
    logic [DATA_WIDTH_OUT-1:0] head_re, head_im;

    assign head_re = dl_re_q[DELAY-1];
    assign head_im = dl_im_q[DELAY-1];

    // Head was written in FILL from a DATA_WIDTH_IN input, so dropping the top bit is lossless in BFLY.
    assign bf_ain_real = head_re[DATA_WIDTH_IN-1:0];
    assign bf_ain_imag = head_im[DATA_WIDTH_IN-1:0];
    assign bf_bin_real = in_real;
    assign bf_bin_imag = in_imag;

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;

    always_comb begin
        idx         = (in_valid && in_sof) ? '0 : cnt_q;
        is_bfly     = idx[CW-1];
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        dl_re_d     = dl_re_q;
        dl_im_d     = dl_im_q;
        if (in_valid) begin
            cnt_d       = idx + CW'(1);
            primed_d    = primed_q | is_bfly;
            out_valid_d = primed_q | is_bfly;
            out_real_d  = is_bfly ? bf_aout_real : head_re;
            out_imag_d  = is_bfly ? bf_aout_imag : head_im;
            for (int i = DELAY - 1; i > 0; i--) begin
                dl_re_d[i] = dl_re_q[i-1];
                dl_im_d[i] = dl_im_q[i-1];
            end
            // BFLY feeds the difference back; it leaves as output during the next block's FILL.
            dl_re_d[0] = is_bfly ? bf_bout_real : {{EW{in_real[DATA_WIDTH_IN-1]}}, in_real};
            dl_im_d[0] = is_bfly ? bf_bout_imag : {{EW{in_imag[DATA_WIDTH_IN-1]}}, in_imag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            for (int i = 0; i < DELAY; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            dl_re_q     <= dl_re_d;
            dl_im_q     <= dl_im_d;
        end
    end
endmodule

// File: tb/tb_radix2_sdf_delay_stage.sv
// tb/tb_radix2_sdf_delay_stage.sv - randomized and directed bench for radix2_sdf_delay_stage
module tb_radix2_sdf_delay_stage;
    localparam int DWI = 10;
    localparam int DWO = 11;
    localparam int D   = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [DWI-1:0] in_real = '0, in_imag = '0;
    logic [DWI-1:0] bf_ain_real, bf_ain_imag, bf_bin_real, bf_bin_imag;
    logic [DWO-1:0] bf_aout_real, bf_aout_imag, bf_bout_real, bf_bout_imag;
    logic           out_valid;
    logic [DWO-1:0] out_real, out_imag;

    int vectors = 0;
    int miscompares = 0;

    int  m_idx;
    int  m_qre[$];
    int  m_qim[$];
    bit  m_primed;
    bit  e_v;
    int  e_re, e_im;

    radix2_sdf_delay_stage #(.DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(DWO), .DELAY(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_real(in_real), .in_imag(in_imag),
        .bf_ain_real(bf_ain_real), .bf_ain_imag(bf_ain_imag),
        .bf_bin_real(bf_bin_real), .bf_bin_imag(bf_bin_imag),
        .bf_aout_real(bf_aout_real), .bf_aout_imag(bf_aout_imag),
        .bf_bout_real(bf_bout_real), .bf_bout_imag(bf_bout_imag),
        .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag)
    );

    // External butterfly: one bit of growth, exact two's-complement arithmetic.
    assign bf_aout_real = {bf_ain_real[DWI-1], bf_ain_real} + {bf_bin_real[DWI-1], bf_bin_real};
    assign bf_aout_imag = {bf_ain_imag[DWI-1], bf_ain_imag} + {bf_bin_imag[DWI-1], bf_bin_imag};
    assign bf_bout_real = {bf_ain_real[DWI-1], bf_ain_real} - {bf_bin_real[DWI-1], bf_bin_real};
    assign bf_bout_imag = {bf_ain_imag[DWI-1], bf_ain_imag} - {bf_bin_imag[DWI-1], bf_bin_imag};

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap_in(input int x);
        int y;
        y = x & ((1 << DWI) - 1);
        return (y >= (1 << (DWI - 1))) ? y - (1 << DWI) : y;
    endfunction

    task automatic model_reset();
        m_idx = 0;
        m_primed = 0;
        m_qre = {};
        m_qim = {};
        for (int i = 0; i < D; i++) begin
            m_qre.push_back(0);
            m_qim.push_back(0);
        end
        e_v = 0; e_re = 0; e_im = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input int re, input int im, input bit r);
        int i, hr, hi, ar, ai;
        bit bfly;
        if (r) begin
            model_reset();
            return;
        end
        e_v = 0;
        if (!v) return;
        i = s ? 0 : m_idx;
        bfly = (i >= D);
        hr = m_qre.pop_front();
        hi = m_qim.pop_front();
        if (bfly) begin
            ar = wrap_in(hr);
            ai = wrap_in(hi);
            m_qre.push_back(ar - re);
            m_qim.push_back(ai - im);
            e_re = ar + re;
            e_im = ai + im;
        end else begin
            m_qre.push_back(re);
            m_qim.push_back(im);
            e_re = hr;
            e_im = hi;
        end
        e_v = m_primed || bfly;
        m_primed = m_primed || bfly;
        m_idx = (i + 1) % (2 * D);
    endtask

    task automatic step(input bit v, input bit s, input int re, input int im, input bit r);
        @(negedge clk);
        rst = r;
        in_valid = v;
        in_sof = s;
        in_real = re[DWI-1:0];
        in_imag = im[DWI-1:0];
        model_step(v, s, re, im, r);
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(e_v));
        check("out_real", int'($signed(out_real)), e_re);
        check("out_imag", int'($signed(out_imag)), e_im);
    endtask

    task automatic ramp(input bit first_sof, input bit gaps);
        for (int k = 1; k <= 2 * D; k++) begin
            step(1, first_sof && k == 1, k, 0, 0);
            if (k > D) check("ramp_sum", int'($signed(out_real)), 2 * k - D);
            else check("ramp_fill_quiet", int'(out_valid), 0);
            if (gaps) begin
                step(0, 0, $urandom_range(0, 1023), 0, 0);
                check("gap_hold", int'(out_valid), 0);
            end
        end
        for (int k = 0; k < 2 * D; k++) begin
            step(1, 0, 0, 0, 0);
            check("ramp_tail", int'($signed(out_real)), (k < D) ? -D : 0);
            check("ramp_tail_v", int'(out_valid), 1);
            if (gaps) step(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        model_reset();
        step(0, 0, 0, 0, 1);
        step(1, 1, 5, 5, 1);
        check("reset_quiet", int'(out_valid), 0);

        ramp(1, 0);

        step(0, 0, 0, 0, 1);
        ramp(1, 1);

        // Extremes: a stored in FILL, b arrives in BFLY; the difference returns in the next FILL.
        step(0, 0, 0, 0, 1);
        step(1, 1, -512, 511, 0);
        for (int k = 1; k < D; k++) step(1, 0, k, -k, 0);
        step(1, 0, -512, -512, 0);
        check("ext_sum_re", int'($signed(out_real)), -1024);
        check("ext_sum_im", int'($signed(out_imag)), -1);
        for (int k = 1; k < D; k++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("ext_diff_re", int'($signed(out_real)), 0);
        check("ext_diff_im", int'($signed(out_imag)), 1023);

        // Resync at index 2 of a block.
        step(1, 1, 9, 9, 0);
        step(1, 0, 8, 8, 0);
        step(1, 1, 100, 0, 0);
        for (int k = 1; k < D; k++) step(1, 0, k, 0, 0);
        step(1, 0, 7, 0, 0);
        check("resync_sum", int'($signed(out_real)), 107);

        // Reset at index 6 with a sample present, then a clean ramp without sof.
        step(0, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) step(1, k == 1, 20 * k, 3, 0);
        step(1, 0, 77, 77, 1);
        check("rst_mid_v", int'(out_valid), 0);
        check("rst_mid_re", int'($signed(out_real)), 0);
        ramp(0, 0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                 wrap_in(int'($urandom)), wrap_in(int'($urandom)),
                 ($urandom_range(0, 150) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
